// File: rtl/collision_event_unit.sv
// ============================================================================
// collision_event_unit
// Per-frame sequential collision scanner (paddles, floor, ceiling) with an
// event FIFO drained over valid/ready.
// Optional build macro: COLLISION_EDGE_DETECT_EN (emit on contact entry only).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_event_unit #(
  parameter int BIT_WIDTH     = 10,
  parameter int NUM_PADDLES   = 2,
  parameter int BALL_RADIUS   = 4,
  parameter int PADDLE_RADIUS = 16,
  parameter int FLOOR_Y       = 0,
  parameter int CEILING_Y     = 479,
  parameter int EVENT_DEPTH   = 4,
  localparam int IDX_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sample,
  input  logic [NUM_PADDLES*BIT_WIDTH-1:0] paddleX,
  input  logic [NUM_PADDLES*BIT_WIDTH-1:0] paddleY,
  input  logic [BIT_WIDTH-1:0]             ballX,
  input  logic [BIT_WIDTH-1:0]             ballY,
  output logic                             busy,
  output logic                             eventValid,
  input  logic                             eventReady,
  output logic [1:0]                       eventType,
  output logic [IDX_W-1:0]                 eventPaddle,
  output logic                             overflow
);

  localparam int c_aw  = $clog2(EVENT_DEPTH);
  localparam int c_src = NUM_PADDLES + 2;
  localparam int c_ew  = 2 + IDX_W;
  localparam logic [BIT_WIDTH:0] c_ball_r    = (BIT_WIDTH+1)'(BALL_RADIUS);
  localparam logic [BIT_WIDTH:0] c_pad_r     = (BIT_WIDTH+1)'(PADDLE_RADIUS);
  localparam logic [BIT_WIDTH:0] c_floor_lim = (BIT_WIDTH+1)'(FLOOR_Y + BALL_RADIUS);
  localparam logic [BIT_WIDTH:0] c_ceil      = (BIT_WIDTH+1)'(CEILING_Y);

  typedef enum logic [1:0] {S_IDLE, S_PADDLE, S_FLOOR, S_CEILING} state_t;

  state_t                           r_state, w_state_nxt;
  logic [IDX_W-1:0]                 r_idx;
  logic [NUM_PADDLES*BIT_WIDTH-1:0] r_px, r_py;
  logic [BIT_WIDTH-1:0]             r_bx, r_by;
  logic [c_src-1:0]                 r_prev, w_src_sel;
  logic [BIT_WIDTH-1:0]             w_px, w_py;
  logic [BIT_WIDTH:0]               w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_bx, w_by;
  logic                             w_hit_paddle, w_hit_floor, w_hit_ceil;
  logic                             w_contact, w_emit;
  logic [1:0]                       w_type;
  logic [IDX_W-1:0]                 w_pidx;
  logic [c_ew-1:0]                  r_mem [EVENT_DEPTH];
  logic [c_aw:0]                    r_wr, r_rd;
  logic                             r_overflow;
  logic                             w_empty, w_full, w_pop, w_push;
  logic [c_ew-1:0]                  w_head;

  always_comb begin
    w_px = '0;
    w_py = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_px = r_px[i*BIT_WIDTH +: BIT_WIDTH];
        w_py = r_py[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Contact windows are computed one bit wider; lower bounds clamp at zero.
  assign w_bx   = {1'b0, r_bx};
  assign w_by   = {1'b0, r_by};
  assign w_x_lo = ({1'b0, w_px} >= c_ball_r) ? {1'b0, w_px} - c_ball_r : '0;
  assign w_x_hi = {1'b0, w_px} + c_ball_r;
  assign w_y_lo = ({1'b0, w_py} >= c_pad_r) ? {1'b0, w_py} - c_pad_r : '0;
  assign w_y_hi = {1'b0, w_py} + c_pad_r;
  assign w_hit_paddle = (w_bx >= w_x_lo) && (w_bx <= w_x_hi) &&
                        (w_by >= w_y_lo) && (w_by <= w_y_hi);
  assign w_hit_floor  = w_by <= c_floor_lim;
  assign w_hit_ceil   = (w_by + c_ball_r) >= c_ceil;

  always_comb begin
    w_state_nxt = r_state;
    w_src_sel   = '0;
    w_contact   = 1'b0;
    w_type      = 2'd0;
    w_pidx      = '0;
    case (r_state)
      S_IDLE: if (sample) w_state_nxt = S_PADDLE;
      S_PADDLE: begin
        w_contact = w_hit_paddle;
        w_pidx    = r_idx;
        w_src_sel = c_src'(1) << r_idx;
        if (r_idx == IDX_W'(NUM_PADDLES - 1)) w_state_nxt = S_FLOOR;
      end
      S_FLOOR: begin
        w_contact   = w_hit_floor;
        w_type      = 2'd1;
        w_src_sel   = {2'b01, {NUM_PADDLES{1'b0}}};
        w_state_nxt = S_CEILING;
      end
      S_CEILING: begin
        w_contact   = w_hit_ceil;
        w_type      = 2'd2;
        w_src_sel   = {2'b10, {NUM_PADDLES{1'b0}}};
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef COLLISION_EDGE_DETECT_EN
  assign w_emit = w_contact && !(|(r_prev & w_src_sel));
`else
  assign w_emit = w_contact;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= (r_prev & ~w_src_sel) | (w_src_sel & {c_src{w_contact}});
      if (r_state == S_IDLE && sample) begin
        r_idx <= '0;
        r_px  <= paddleX;
        r_py  <= paddleY;
        r_bx  <= ballX;
        r_by  <= ballY;
      end else if (r_state == S_PADDLE && r_idx != IDX_W'(NUM_PADDLES - 1)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Event FIFO: a full FIFO still accepts a push when the head pops that cycle.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
  assign w_pop   = !w_empty && eventReady;
  assign w_push  = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[c_aw-1:0]] <= {w_type, w_pidx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_emit && !w_push) r_overflow <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd[c_aw-1:0]];
  assign busy        = (r_state != S_IDLE);
  assign eventValid  = !w_empty;
  assign eventType   = eventValid ? w_head[c_ew-1 -: 2] : 2'd0;
  assign eventPaddle = eventValid ? w_head[IDX_W-1:0] : '0;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_collision_event_unit.sv
// ============================================================================
// tb_collision_event_unit
// Self-checking bench: directed scenarios plus randomized frames against a
// behavioural contact/event-queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_event_unit;

  localparam int BW = 10;
  localparam int N  = 2;
  localparam int BR = 4;
  localparam int PR = 16;
  localparam int FY = 0;
  localparam int CY = 479;
  localparam int D  = 4;
  localparam int IW = 1;
`ifdef COLLISION_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n, sample, eventReady;
  logic [N*BW-1:0]   paddleX, paddleY;
  logic [BW-1:0]     ballX, ballY;
  logic              busy, eventValid, overflow;
  logic [1:0]        eventType;
  logic [IW-1:0]     eventPaddle;

  collision_event_unit #(
    .BIT_WIDTH(BW), .NUM_PADDLES(N), .BALL_RADIUS(BR), .PADDLE_RADIUS(PR),
    .FLOOR_Y(FY), .CEILING_Y(CY), .EVENT_DEPTH(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample(sample),
    .paddleX(paddleX), .paddleY(paddleY), .ballX(ballX), .ballY(ballY),
    .busy(busy), .eventValid(eventValid), .eventReady(eventReady),
    .eventType(eventType), .eventPaddle(eventPaddle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int p; } ev_t;
  ev_t mq[$];
  bit  mprev[N+2];
  bit  movf;
  int  cur_px[N], cur_py[N], cur_bx, cur_by;
  int  vectors = 0, miscompares = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  function automatic int sat0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_clear;
    mq.delete();
    for (int s = 0; s < N + 2; s++) mprev[s] = 1'b0;
    movf = 1'b0;
  endtask

  // One frame: sources in order, each contact filtered by the emit rule.
  task automatic model_scan;
    bit c;
    for (int s = 0; s < N + 2; s++) begin
      if (s < N)
        c = (cur_bx >= sat0(cur_px[s] - BR)) && (cur_bx <= cur_px[s] + BR) &&
            (cur_by >= sat0(cur_py[s] - PR)) && (cur_by <= cur_py[s] + PR);
      else if (s == N) c = (cur_by <= FY + BR);
      else             c = (cur_by + BR >= CY);
      if (c && (!EDGE || !mprev[s])) begin
        if (mq.size() < D) mq.push_back('{(s < N) ? 0 : (s == N) ? 1 : 2, (s < N) ? s : 0});
        else movf = 1'b1;
      end
      mprev[s] = c;
    end
  endtask

  task automatic drive_pos;
    for (int i = 0; i < N; i++) begin
      paddleX[i*BW +: BW] = BW'(cur_px[i]);
      paddleY[i*BW +: BW] = BW'(cur_py[i]);
    end
    ballX = BW'(cur_bx);
    ballY = BW'(cur_by);
  endtask

  task automatic set_frame(input int bx, input int by, input int p0x, input int p0y,
                           input int p1x, input int p1y);
    cur_bx = bx; cur_by = by;
    cur_px[0] = p0x; cur_py[0] = p0y;
    cur_px[1] = p1x; cur_py[1] = p1y;
  endtask

  task automatic start_scan;
    drive_pos();
    sample = 1'b1;
    tick();
    sample = 1'b0;
    model_scan();
  endtask

  task automatic wait_idle;
    int c = 0;
    while (busy && c < 50) begin tick(); c++; end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL scan_timeout: busy=%0b required 0", busy);
      miscompares++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    logic [1:0] et;
    logic [IW-1:0] ep;
    n = mq.size();
    eventReady = 1'b1;
    for (int k = 0; k < n; k++) begin
      et = 2'(mq[0].t);
      ep = IW'(mq[0].p);
      vectors++;
      if (eventValid !== 1'b1 || eventType !== et || eventPaddle !== ep) begin
        $display("FAIL %s event%0d: valid=%0b type=%0d paddle=%0d required valid=1 type=%0d paddle=%0d",
                 name, k, eventValid, eventType, eventPaddle, et, ep);
        miscompares++;
      end
      void'(mq.pop_front());
      tick();
    end
    eventReady = 1'b0;
    vectors++;
    if (eventValid !== 1'b0) begin
      $display("FAIL %s extra_event: valid=%0b type=%0d required valid=0", name, eventValid, eventType);
      miscompares++;
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (busy !== 1'b0 || eventValid !== 1'b0 || eventType !== 2'd0 ||
        eventPaddle !== '0 || overflow !== 1'b0) begin
      $display("FAIL %s: busy=%0b valid=%0b type=%0d paddle=%0d ovf=%0b required all 0",
               name, busy, eventValid, eventType, eventPaddle, overflow);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; sample = 1'b0; eventReady = 1'b0;
    set_frame(0, 0, 0, 0, 0, 0);
    drive_pos();
    tick(); tick();
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    model_clear();
    tick();
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_timing;
    do_reset();
    set_frame(100, 200, 100, 190, 500, 200);
    start_scan();
    for (int k = 1; k <= N + 3; k++) begin
      vectors++;
      if (busy !== (k <= N + 2)) begin
        $display("FAIL busy_cycle%0d: busy=%0b required %0b", k, busy, (k <= N + 2));
        miscompares++;
      end
      if (k == 1) begin
        vectors++;
        if (eventValid !== 1'b0) begin
          $display("FAIL push_latency_c1: valid=%0b required 0", eventValid);
          miscompares++;
        end
      end
      if (k == 2) begin
        vectors++;
        if (eventValid !== 1'b1 || eventType !== 2'd0 || eventPaddle !== '0) begin
          $display("FAIL push_latency_c2: valid=%0b type=%0d paddle=%0d required 1/0/0",
                   eventValid, eventType, eventPaddle);
          miscompares++;
        end
      end
      if (k < N + 3) tick();
    end
    drain("timing");
  endtask

  task automatic test_edge;
    do_reset();
    set_frame(100, 200, 100, 190, 500, 200);
    start_scan(); wait_idle(); drain("edge_first");
    start_scan(); wait_idle(); drain("edge_second");
  endtask

  task automatic test_walls;
    do_reset();
    set_frame(300, 4, 900, 600, 20, 600);
    start_scan(); wait_idle(); drain("floor_at_limit");
    cur_by = 5;
    start_scan(); wait_idle(); drain("floor_above");
    cur_by = 475;
    start_scan(); wait_idle(); drain("ceiling");
  endtask

  task automatic test_saturation;
    do_reset();
    set_frame(300, 0, 300, 5, 800, 500);
    start_scan(); wait_idle(); drain("sat_low");
    do_reset();
    set_frame(300, 1023, 300, 1020, 800, 500);
    start_scan(); wait_idle(); drain("sat_high");
  endtask

  task automatic test_busy_ignored;
    do_reset();
    set_frame(100, 200, 100, 190, 500, 200);
    start_scan();
    sample = 1'b1;
    tick(); tick();
    sample = 1'b0;
    wait_idle();
    drain("busy_ignored");
  endtask

  task automatic test_overflow;
    do_reset();
    set_frame(100, 2, 100, 10, 500, 200);
    for (int s = 0; s < 3; s++) begin start_scan(); wait_idle(); end
    vectors++;
    if (overflow !== movf) begin
      $display("FAIL overflow_set: overflow=%0b required %0b", overflow, movf);
      miscompares++;
    end
    drain("overflow_order");
    vectors++;
    if (overflow !== movf) begin
      $display("FAIL overflow_sticky: overflow=%0b required %0b", overflow, movf);
      miscompares++;
    end
  endtask

  task automatic test_full_pop_push;
    logic [1:0] et;
    do_reset();
    set_frame(100, 200, 100, 190, 500, 200);
    for (int s = 0; s < D; s++) begin start_scan(); wait_idle(); end
    drive_pos();
    sample = 1'b1;
    tick();
    sample = 1'b0;
    et = 2'(mq[0].t);
    vectors++;
    if (eventValid !== 1'b1 || eventType !== et) begin
      $display("FAIL full_head: valid=%0b type=%0d required 1/%0d", eventValid, eventType, et);
      miscompares++;
    end
    eventReady = 1'b1;
    void'(mq.pop_front());
    model_scan();
    tick();
    eventReady = 1'b0;
    wait_idle();
    vectors++;
    if (overflow !== movf) begin
      $display("FAIL full_pop_push_overflow: overflow=%0b required %0b", overflow, movf);
      miscompares++;
    end
    drain("full_pop_push");
  endtask

  task automatic test_reset_midscan;
    do_reset();
    set_frame(100, 200, 100, 190, 500, 200);
    start_scan();
    tick();
    vectors++;
    if (eventValid !== 1'b1) begin
      $display("FAIL midscan_inflight: valid=%0b required 1", eventValid);
      miscompares++;
    end
    reset_n = 1'b0;
    tick();
    check_reset_outputs("reset_midscan");
    reset_n = 1'b1;
    model_clear();
    start_scan(); wait_idle(); drain("after_midscan_reset");
  endtask

  task automatic test_random;
    int k, dx, dy;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        cur_px[i] = int'($urandom_range(0, 1023));
        cur_py[i] = int'($urandom_range(0, 1023));
      end
      cur_bx = int'($urandom_range(0, 1023));
      cur_by = int'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0: begin
          k  = int'($urandom_range(0, N - 1));
          dx = int'($urandom_range(0, 2 * BR + 2)) - BR - 1;
          dy = int'($urandom_range(0, 2 * PR + 2)) - PR - 1;
          cur_bx = clamp(cur_px[k] + dx);
          cur_by = clamp(cur_py[k] + dy);
        end
        1: cur_by = int'($urandom_range(0, 8));
        2: cur_by = int'($urandom_range(468, 490));
        default: ;
      endcase
      start_scan(); wait_idle(); drain("random");
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_edge();
    test_walls();
    test_saturation();
    test_busy_ignored();
`ifndef COLLISION_EDGE_DETECT_EN
    test_overflow();
    test_full_pop_push();
`endif
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
